// File: rtl/mem_ctrl.sv
// Byte-wide RAM port arbiter: serves icache line refills and LSU loads/stores
// one byte per cycle, round-robin on ties, with rollback abort of reads.
module mem_ctrl #(
  parameter int LINE_BYTES = 16,
  parameter int ADDR_W     = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rb,
  input  logic                    ic_req,
  input  logic [ADDR_W-1:0]       ic_addr,
  output logic                    ic_done,
  output logic [LINE_BYTES*8-1:0] ic_data,
  input  logic                    ls_req,
  input  logic                    ls_wr,
  input  logic [1:0]              ls_len,
  input  logic [ADDR_W-1:0]       ls_addr,
  input  logic [31:0]             ls_wdata,
  output logic                    ls_done,
  output logic [31:0]             ls_rdata,
  input  logic [7:0]              mem_din,
  output logic [7:0]              mem_dout,
  output logic [ADDR_W-1:0]       mem_a,
  output logic                    mem_wr,
  input  logic                    io_full
);

  localparam int IW = $clog2(LINE_BYTES);
  localparam int CW = IW + 1;

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t                          state, state_nx;
  logic [CW-1:0]                   cnt, n_bytes, ls_n;
  logic [ADDR_W-1:0]               base;
  logic [3:0][7:0]                 wdata;
  logic [LINE_BYTES-1:0][7:0]      line_q, line_nx, ic_line;
  logic                            gnt_ic, last_ic;
  logic                            grant, pick_ic, stall;
  logic [IW-1:0]                   cap_idx;

  assign ic_data = ic_line;

  always_comb begin
    case (ls_len)
      2'd0:    ls_n = CW'(1);
      2'd1:    ls_n = CW'(2);
      default: ls_n = CW'(4);
    endcase
  end

  // requests are ignored during rollback; on a tie the side not served last wins
  assign grant   = !rb && (ic_req || ls_req);
  assign pick_ic = ic_req && (!ls_req || !last_ic);
  assign stall   = (base[17:16] == 2'b11) && io_full;
  assign cap_idx = IW'(cnt - CW'(1));

  // byte for the address driven last cycle lands in slot cnt-1
  always_comb begin
    line_nx = line_q;
    if (state == RD && cnt != '0) line_nx[cap_idx] = mem_din;
  end

  always_comb begin
    state_nx = state;
    mem_a    = '0;
    mem_wr   = 1'b0;
    mem_dout = '0;
    ic_done  = 1'b0;
    ls_done  = 1'b0;
    case (state)
      IDLE: if (grant) state_nx = (pick_ic || !ls_wr) ? RD : WR;
      RD: begin
        if (cnt < n_bytes) mem_a = base + ADDR_W'(cnt);
        if (rb)                  state_nx = IDLE;
        else if (cnt == n_bytes) state_nx = DONE;
      end
      WR: begin
        mem_a = base + ADDR_W'(cnt);
        if (!stall) begin
          mem_wr   = 1'b1;
          mem_dout = wdata[cnt[1:0]];
          if (cnt == n_bytes - CW'(1)) state_nx = DONE;
        end
      end
      DONE: begin
        ic_done  = gnt_ic;
        ls_done  = !gnt_ic;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      n_bytes  <= '0;
      base     <= '0;
      wdata    <= '0;
      line_q   <= '0;
      ic_line  <= '0;
      ls_rdata <= '0;
      gnt_ic   <= 1'b0;
      last_ic  <= 1'b1;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (grant) begin
          gnt_ic  <= pick_ic;
          last_ic <= pick_ic;
          cnt     <= '0;
          line_q  <= '0;
          if (pick_ic) begin
            base    <= ic_addr;
            n_bytes <= CW'(LINE_BYTES);
          end else begin
            base    <= ls_addr;
            n_bytes <= ls_n;
            wdata   <= ls_wdata;
          end
        end
        RD: begin
          if (rb) cnt <= '0;
          else begin
            line_q <= line_nx;
            // outputs change only once the whole transfer has landed
            if (cnt == n_bytes) begin
              if (gnt_ic) ic_line  <= line_nx;
              else        ls_rdata <= line_nx[3:0];
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        WR: if (!stall) cnt <= cnt + CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: drivers push expected responses/writes,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_mem_ctrl;
  localparam int LB = 16;
  localparam int AW = 32;
  localparam logic [LB*8-1:0] L40 = 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0;
  localparam logic [LB*8-1:0] L50 = 128'hBFBEBDBCBBBAB9B8B7B6B5B4B3B2B1B0;

  logic          clk = 0, rst = 1, rb = 0, ic_req = 0, ls_req = 0, ls_wr = 0, io_full = 0;
  logic [1:0]    ls_len = 0;
  logic [AW-1:0] ic_addr = 0, ls_addr = 0, mem_a;
  logic [31:0]   ls_wdata = 0, ls_rdata;
  logic [7:0]    mem_din = 0, mem_dout;
  logic          ic_done, ls_done, mem_wr;
  logic [LB*8-1:0] ic_data;

  mem_ctrl #(.LINE_BYTES(LB), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .rb(rb),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_done(ic_done), .ic_data(ic_data),
    .ls_req(ls_req), .ls_wr(ls_wr), .ls_len(ls_len), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_full(io_full)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;

  function automatic logic [7:0] ram_init(int i);
    if (i >= 'h40 && i < 'h50) return 8'hA0 + 8'(i - 'h40);
    if (i >= 'h50 && i < 'h60) return 8'hB0 + 8'(i - 'h50);
    case (i)
      'h100: return 8'h11;
      'h101: return 8'h22;
      'h102: return 8'h33;
      'h103: return 8'h44;
      'h007: return 8'hF0;
      'h3FE: return 8'h5E;
      'h3FF: return 8'h6F;
      'h000: return 8'h70;
      'h001: return 8'h81;
      default: return 8'(i);
    endcase
  endfunction

  // 1 KiB RAM model, 1-cycle read latency, preloaded while rst is high
  logic [7:0] ram [0:1023];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) ram[i] <= ram_init(i);
    end else begin
      mem_din <= ram[mem_a[9:0]];
      if (mem_wr) ram[mem_a[9:0]] <= mem_dout;
    end
  end

  typedef struct { logic [LB*8-1:0] data; int cyc; bit chk; } resp_t;
  typedef struct { logic [AW-1:0] a; logic [7:0] d; int cyc; } wr_t;
  typedef struct { logic [AW-1:0] a; int cyc; } rd_t;
  resp_t ic_q[$], ls_q[$];
  wr_t   wr_q[$];
  rd_t   rd_q[$];

  resp_t mr;
  wr_t   mw;
  rd_t   ma;

  always @(negedge clk) begin
    if (wr_q.size() > 0 && wr_q[0].cyc < cyc) begin
      checks++; errors++;
      $display("FAIL write_missing: expected %h@%h in cycle %0d, absent", wr_q[0].d, wr_q[0].a, wr_q[0].cyc);
      void'(wr_q.pop_front());
    end
    if (mem_wr) begin
      checks++;
      if (wr_q.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected: got %h@%h in cycle %0d, required none", mem_dout, mem_a, cyc);
      end else begin
        mw = wr_q.pop_front();
        if (mem_a !== mw.a || mem_dout !== mw.d || cyc != mw.cyc) begin
          errors++;
          $display("FAIL write: got %h@%h cyc %0d, required %h@%h cyc %0d", mem_dout, mem_a, cyc, mw.d, mw.a, mw.cyc);
        end
      end
    end
    if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
      ma = rd_q.pop_front();
      checks++;
      if (mem_a !== ma.a) begin
        errors++;
        $display("FAIL read_addr: cycle %0d got %h, required %h", cyc, mem_a, ma.a);
      end
    end
    if (ic_done) begin
      checks++;
      if (ic_q.size() == 0) begin
        errors++;
        $display("FAIL ic_done_unexpected: pulse in cycle %0d, required none", cyc);
      end else begin
        mr = ic_q.pop_front();
        if (ic_data !== mr.data || cyc != mr.cyc) begin
          errors++;
          $display("FAIL ic_resp: got %h cyc %0d, required %h cyc %0d", ic_data, cyc, mr.data, mr.cyc);
        end
      end
    end
    if (ls_done) begin
      checks++;
      if (ls_q.size() == 0) begin
        errors++;
        $display("FAIL ls_done_unexpected: pulse in cycle %0d, required none", cyc);
      end else begin
        mr = ls_q.pop_front();
        if ((mr.chk && ls_rdata !== mr.data[31:0]) || cyc != mr.cyc) begin
          errors++;
          $display("FAIL ls_resp: got %h cyc %0d, required %h cyc %0d", ls_rdata, cyc, mr.data[31:0], mr.cyc);
        end
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [LB*8-1:0] act, input logic [LB*8-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic ic_refill(input logic [AW-1:0] addr, input logic [LB*8-1:0] exp, input int exp_cyc);
    bit got = 0;
    ic_q.push_back('{exp, exp_cyc, 1'b1});
    ic_addr = addr;
    ic_req  = 1;
    for (int i = 0; i < 80 && !got; i++) begin
      step;
      got = ic_done;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL ic_timeout: no ic_done for %h, required by cycle %0d", addr, exp_cyc);
    end
    step;
    ic_req = 0;
  endtask

  task automatic ls_access(input logic wr, input logic [1:0] len, input logic [AW-1:0] addr,
                           input logic [31:0] wd, input logic [31:0] exp, input int exp_cyc);
    bit got = 0;
    ls_q.push_back('{{96'b0, exp}, exp_cyc, !wr});
    ls_wr = wr; ls_len = len; ls_addr = addr; ls_wdata = wd;
    ls_req = 1;
    for (int i = 0; i < 80 && !got; i++) begin
      step;
      got = ls_done;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL ls_timeout: no ls_done for %h, required by cycle %0d", addr, exp_cyc);
    end
    step;
    ls_req = 0;
  endtask

  initial begin
    int c;
    repeat (3) step;
    chk("rst_ic_data", ic_data, '0);
    chk("rst_ls_rdata", {96'b0, ls_rdata}, '0);
    chk("rst_mem_a", {96'b0, mem_a}, '0);
    chk("rst_mem_dout", {120'b0, mem_dout}, '0);
    chk("rst_strobes", {125'b0, mem_wr, ic_done, ls_done}, '0);
    rst = 0;

    // first tie goes to LSU: word load, then the refill
    c = cyc;
    for (int k = 0; k < 4; k++) rd_q.push_back('{32'h100 + k, c + 1 + k});
    fork
      ls_access(0, 2'd2, 32'h100, 0, 32'h44332211, c + 6);
      ic_refill(32'h40, L40, c + 25);
    join

    // last grant IC, so LSU wins again: byte load clears upper bytes
    c = cyc;
    fork
      ls_access(0, 2'd0, 32'h7, 0, 32'h000000F0, c + 3);
      ic_refill(32'h50, L50, c + 22);
    join

    // half store to I/O space, io_full high for cycles 1..3
    c = cyc;
    wr_q.push_back('{32'h30004, 8'hEF, c + 4});
    wr_q.push_back('{32'h30005, 8'hBE, c + 5});
    fork
      ls_access(1, 2'd1, 32'h30004, 32'h0000BEEF, 0, c + 6);
      begin step; io_full = 1; step; step; step; io_full = 0; end
    join

    // last grant LSU, so the refill wins the tie; load wraps past 2^32
    c = cyc;
    fork
      ic_refill(32'h40, L40, c + 18);
      ls_access(0, 2'd2, 32'hFFFFFFFE, 0, 32'h81706F5E, c + 25);
    join

    // rollback in cycle 3 of a refill aborts it; pending load served next
    c = cyc;
    ic_addr = 32'h50;
    ic_req  = 1;
    fork
      begin step; ls_access(0, 2'd2, 32'h100, 0, 32'h44332211, c + 10); end
      begin step; step; step; rb = 1; step; rb = 0; ic_req = 0; end
    join
    chk("ic_data_hold_after_abort", ic_data, L40);

    // rollback cannot abort a store; non-I/O address ignores io_full
    c = cyc;
    wr_q.push_back('{32'h200, 8'hEF, c + 1});
    wr_q.push_back('{32'h201, 8'hBE, c + 2});
    wr_q.push_back('{32'h202, 8'hAD, c + 3});
    wr_q.push_back('{32'h203, 8'hDE, c + 4});
    fork
      ls_access(1, 2'd2, 32'h200, 32'hDEADBEEF, 0, c + 5);
      begin io_full = 1; step; step; rb = 1; step; rb = 0; end
    join
    io_full = 0;
    c = cyc;
    ls_access(0, 2'd2, 32'h200, 0, 32'hDEADBEEF, c + 6);

    // reset in cycle 2 of a word store
    c = cyc;
    wr_q.push_back('{32'h30008, 8'h78, c + 1});
    ls_wr = 1; ls_len = 2'd2; ls_addr = 32'h30008; ls_wdata = 32'h12345678;
    ls_req = 1;
    step; step;
    #2 rst = 1;
    #1;
    chk("midrst_mem_wr", {127'b0, mem_wr}, '0);
    chk("midrst_mem_a", {96'b0, mem_a}, '0);
    chk("midrst_mem_dout", {120'b0, mem_dout}, '0);
    chk("midrst_ls_rdata", {96'b0, ls_rdata}, '0);
    chk("midrst_ic_data", ic_data, '0);
    ls_req = 0;
    step; step;
    rst = 0;

    // last_grant back to IC after reset: LSU wins
    c = cyc;
    fork
      ic_refill(32'h50, L50, c + 22);
      ls_access(0, 2'd0, 32'h7, 0, 32'h000000F0, c + 3);
    join

    repeat (4) step;
    chk("pending_expectations", 128'(ic_q.size() + ls_q.size() + wr_q.size() + rd_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

endmodule
